dct_row_packer: RTL and testbench
=================================

Name: dct_row_packer

Overview:
- Front end of the 2D DCT datapath in the JPEG accelerator.
- Takes 32-bit words of unsigned 8-bit pixels from the input block buffer and assembles them into 8-pixel rows.
- Applies the JPEG level shift (subtract 128) to each pixel and packs the row as eight 12-bit two's-complement samples on a 96-bit bus.
- Issues one write strobe per row toward the row-DCT/transpose chain and sequences exactly 8 rows per 8x8 block.

Parameters:
- PIX_W, 8, input pixel width in bits.
- COEF_W, 12, output sample width in bits; out_row width is 8*COEF_W.
- ROWS, 8, rows per block.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a block; ignored while busy=1.
- in_valid  input  1  in_data holds a valid word.
- in_data  input  32  four pixels; in_data[31:24] is the leftmost pixel of the pair.
- in_ready  output  1  packer accepts in_data this cycle.
- out_wr  output  1  out_row valid / write strobe to the downstream stage.
- out_row  output  96  packed row; out_row[95:84] is sample 0, out_row[11:0] is sample 7.
- busy  output  1  block in progress.
- done  output  1  one-cycle pulse on the final row write.

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is asynchronous and active-high.
- Reset values: in_ready=0, out_wr=0, out_row=0, busy=0, done=0; FSM goes to IDLE and the row counter to 0.
- Reset mid-block aborts the block immediately. No out_wr is issued for a partial row.
- FSM states: IDLE, WORD0, WORD1.
- IDLE: in_ready=0. start=1 moves to WORD0 next cycle, clears the row counter and sets busy=1. start outside IDLE is ignored.
- WORD0: in_ready=1. A transfer occurs when in_valid&in_ready. The transfer latches pixels 0-3 and moves to WORD1.
- WORD1: in_ready=1. A transfer latches pixels 4-7 and loads out_row.
- On the WORD1 transfer:
  - Next state is WORD0 if this is not the ROWS-th row, else IDLE.
  - out_wr=1 for exactly the following cycle.
- Sample conversion: sample = PIX_W-bit pixel zero-extended to COEF_W, minus 128, kept as COEF_W two's complement. Result range is -128..127; it cannot overflow.
- Latency: out_wr is asserted 1 cycle after the WORD1 transfer.
- Throughput: one row per 2 accepted words. Minimum block time is 16 transfer cycles plus 1.
- in_valid=0 stalls the FSM in its current state with no side effects.
- out_row holds its value between writes. It changes only on a WORD1 transfer or on reset.
- done=1 in the same cycle as the out_wr of row ROWS-1.
- busy stays 1 through the done cycle and is 0 the cycle after. start is accepted again from that cycle.

Optional Feature:
- Macro: PACKER_BACKPRESSURE_EN.
- With the macro defined:
  - An extra input port out_ready (1 bit) is added.
  - out_wr stays high and out_row stays stable until out_ready=1; the row is consumed in the first cycle with out_wr&out_ready.
  - in_ready=0 in WORD1 while a row is pending, so a pending row is never overwritten. WORD0 transfers remain allowed.
  - done is asserted in the cycle the final row is consumed. busy stays 1 until that cycle completes.
- Without the macro: no out_ready port, and out_wr is an unconditional 1-cycle pulse as described above.

Test Plan:
- Reset then idle: hold rst 3 cycles with start=0 -> all outputs 0. Apply in_valid=1 with no start -> in_ready stays 0 and out_wr never asserts.
- Single row, extremes: start, then words 0x00FF807F and 0x01FE8180 -> one out_wr with out_row samples F80,07F,000,FFF,F81,07E,001,000 (hex, 12-bit).
- Full block, no stalls: start, 16 back-to-back words with in_valid=1 -> exactly 8 out_wr pulses, 2 cycles apart. done coincides with the 8th pulse; busy falls 1 cycle later.
- Source stalls: toggle in_valid 1/0 every cycle across a block -> same 8 rows in the same order. out_row is unchanged between strobes.
- Start while busy and reset mid-block: pulse start at row 3 -> ignored, row count unaffected. Assert rst after word 9 -> outputs return to 0 immediately. A new start then yields 8 fresh rows.
- PACKER_BACKPRESSURE_EN: hold out_ready=0 for 5 cycles on row 0 -> out_wr and out_row stay stable, WORD1 in_ready=0, and no row is lost. done is asserted only when row 7 is consumed.

Source files
------------

// File: rtl/dct_row_packer.sv
// JPEG DCT front end: packs two 32-bit pixel words into one level-shifted 8x12-bit row, 8 rows per block.
// Optional macro PACKER_BACKPRESSURE_EN adds out_ready; the row write is then held until consumed.
module dct_row_packer #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 12,
  parameter int ROWS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [31:0]         in_data,
`ifdef PACKER_BACKPRESSURE_EN
  input  logic                out_ready,
`endif
  output logic                in_ready,
  output logic                out_wr,
  output logic [8*COEF_W-1:0] out_row,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, WORD0, WORD1} state_t;

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COEF_W-1:0] HALF = COEF_W'(2 ** (PIX_W - 1));

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [31:0]         w0_q, w0_d;
  logic [8*COEF_W-1:0] out_row_q, out_row_d;
  logic                out_wr_q, out_wr_d;
  logic                busy_q, busy_d;
  logic                last_q, last_d;

  logic xfer, wr_xfer, is_last, consume;

  function automatic logic [COEF_W-1:0] lvl(input logic [PIX_W-1:0] p);
    return COEF_W'(p) - HALF;
  endfunction

  // A pending row blocks the WORD1 transfer so it can never be overwritten.
  assign in_ready = (state_q == WORD0) || ((state_q == WORD1) && !out_wr_q);
  assign xfer     = in_valid && in_ready;
  assign wr_xfer  = xfer && (state_q == WORD1);
  assign is_last  = (row_q == RW'(ROWS - 1));

`ifdef PACKER_BACKPRESSURE_EN
  assign consume = out_wr_q && out_ready;
`else
  assign consume = out_wr_q;
`endif

  assign done    = consume && last_q;
  assign out_wr  = out_wr_q;
  assign out_row = out_row_q;
  assign busy    = busy_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    w0_d      = w0_q;
    out_row_d = out_row_q;
    busy_d    = busy_q;
    last_d    = last_q;
`ifdef PACKER_BACKPRESSURE_EN
    out_wr_d  = wr_xfer || (out_wr_q && !out_ready);
`else
    out_wr_d  = wr_xfer;
`endif

    case (state_q)
      IDLE: begin
        // busy_q still set here means the last row has not been written out yet
        if (start && !busy_q) begin
          state_d = WORD0;
          row_d   = '0;
          busy_d  = 1'b1;
        end
      end
      WORD0: begin
        if (xfer) begin
          w0_d    = in_data;
          state_d = WORD1;
        end
      end
      WORD1: begin
        if (xfer) begin
          for (int i = 0; i < 4; i++) begin
            out_row_d[COEF_W*(7-i) +: COEF_W] = lvl(w0_q[8*(3-i) +: PIX_W]);
            out_row_d[COEF_W*(3-i) +: COEF_W] = lvl(in_data[8*(3-i) +: PIX_W]);
          end
          row_d   = row_q + RW'(1);
          state_d = is_last ? IDLE : WORD0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_xfer)      last_d = is_last;
    else if (consume) last_d = 1'b0;

    if (done) busy_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      w0_q      <= '0;
      out_row_q <= '0;
      out_wr_q  <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      w0_q      <= w0_d;
      out_row_q <= out_row_d;
      out_wr_q  <= out_wr_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_dct_row_packer.sv
// Directed bench for dct_row_packer; inputs change and outputs are checked on the falling edge.
module tb_dct_row_packer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [31:0] in_data;
  logic        in_ready, out_wr, busy, done;
  logic [95:0] out_row;
`ifdef PACKER_BACKPRESSURE_EN
  logic        out_ready;
`endif

  int checks = 0;
  int errors = 0;
  logic [95:0] held_exp;

  always #5 clk = ~clk;

  dct_row_packer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
`ifdef PACKER_BACKPRESSURE_EN
    .out_ready(out_ready),
`endif
    .in_ready (in_ready),
    .out_wr   (out_wr),
    .out_row  (out_row),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int seed, input int w, input int k);
    return 8'((seed * 61 + w * 29 + k * 71 + 13) & 255);
  endfunction

  function automatic logic [31:0] word(input int seed, input int w);
    return {pix(seed, w, 0), pix(seed, w, 1), pix(seed, w, 2), pix(seed, w, 3)};
  endfunction

  function automatic logic [11:0] smp(input logic [7:0] p);
    int v;
    v = int'(p) - 128;
    return 12'(v);
  endfunction

  function automatic logic [95:0] exp_row(input int seed, input int r);
    logic [95:0] x;
    x = '0;
    for (int j = 0; j < 8; j++) x[95 - 12*j -: 12] = smp(pix(seed, 2*r + j/4, j%4));
    return x;
  endfunction

  task automatic run_block(input int seed, input bit stall, input bit mid_start);
    int wi, rows, cyc, prev;
    bit pulsed;
    wi = 0; rows = 0; cyc = 0; prev = 0; pulsed = 0;
    chk("pre_busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    while (rows < 8 && cyc < 200) begin
      if (wi < 16) begin
        in_valid = stall ? (cyc % 2 == 0) : 1'b1;
        in_data  = word(seed, wi);
      end else begin
        in_valid = 1'b0;
      end
      start = mid_start && rows == 3 && !pulsed;
      if (start) pulsed = 1'b1;
      if (in_valid && in_ready) wi++;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (out_wr) begin
        held_exp = exp_row(seed, rows);
        chk("row_data", out_row, held_exp);
        chk("done_at_row", done, rows == 7);
        chk("busy_at_row", busy, 1);
        if (!stall && rows > 0) chk("row_gap", cyc - prev, 2);
        prev = cyc;
        rows++;
      end else begin
        chk("row_hold", out_row, held_exp);
        chk("no_done", done, 0);
      end
    end
    chk("row_count", rows, 8);
    chk("words_taken", wi, 16);
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy_fall", busy, 0);
    chk("wr_after", out_wr, 0);
    chk("done_after", done, 0);
    chk("row_final_hold", out_row, held_exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; held_exp = '0;
`ifdef PACKER_BACKPRESSURE_EN
    out_ready = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    rst = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    repeat (4) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_out_wr", out_wr, 0);
      chk("idle_busy", busy, 0);
    end
    in_valid = 1'b0;

    // single row with extreme pixel values
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("w0_busy", busy, 1);
    chk("w0_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 32'h00FF807F;
    @(negedge clk);
    chk("w1_in_ready", in_ready, 1);
    chk("w1_out_wr", out_wr, 0);
    in_data = 32'h01FE8180;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ext_out_wr", out_wr, 1);
    chk("ext_row", out_row, 96'hF8007F000FFFF8107E001000);
    chk("ext_done", done, 0);
    @(negedge clk);
    chk("ext_wr_pulse", out_wr, 0);
    chk("ext_row_hold", out_row, 96'hF8007F000FFFF8107E001000);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; held_exp = '0;
    chk("abort_row", out_row, 0);
    chk("abort_busy", busy, 0);

    run_block(1, 1'b0, 1'b0);
    run_block(2, 1'b1, 1'b0);
    run_block(4, 1'b0, 1'b1);

    // reset after word 9 of a block
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = word(7, i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_row", out_row, exp_row(7, 3));
    #2 rst = 1'b1;
    #1;
    chk("arst_out_wr", out_wr, 0);
    chk("arst_out_row", out_row, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0; held_exp = '0;
    run_block(9, 1'b0, 1'b0);

`ifdef PACKER_BACKPRESSURE_EN
    begin
      int wi, rows, cyc;
      out_ready = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1; in_data = word(5, 0);
      @(negedge clk);
      in_data = word(5, 1);
      @(negedge clk);
      held_exp = exp_row(5, 0);
      in_data = word(5, 2);
      chk("bp_wr_first", out_wr, 1);
      chk("bp_row_first", out_row, held_exp);
      @(negedge clk);
      in_data = word(5, 3);
      repeat (4) begin
        chk("bp_wr_held", out_wr, 1);
        chk("bp_row_held", out_row, held_exp);
        chk("bp_w1_blocked", in_ready, 0);
        chk("bp_no_done", done, 0);
        @(negedge clk);
      end
      out_ready = 1'b1;
      wi = 3; rows = 0; cyc = 0;
      while (rows < 8 && cyc < 300) begin
        if (wi < 16) begin
          in_valid = 1'b1; in_data = word(5, wi);
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (out_wr && out_ready) begin
          held_exp = exp_row(5, rows);
          chk("bp_row", out_row, held_exp);
          chk("bp_done", done, rows == 7);
          chk("bp_busy", busy, 1);
          rows++;
        end else begin
          chk("bp_idle_done", done, 0);
        end
        if (in_valid && in_ready) wi++;
        @(negedge clk);
        cyc++;
      end
      in_valid = 1'b0;
      chk("bp_rows", rows, 8);
      chk("bp_words", wi, 16);
      chk("bp_busy_fall", busy, 0);
      chk("bp_wr_fall", out_wr, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
